pool2d_stream: RTL
==================

# pool2d_stream

Streaming 2×2, stride-2 pooling stage with runtime-selectable average or max mode and parametrised pixel width and image size. It consumes a raster-order pixel stream from the convolution stage (one pixel per valid cycle, no backpressure) and emits one pooled pixel per 2×2 window, plus row-end and frame-end markers. A half-width line buffer holds the horizontal partial result of each even row until its odd-row partner arrives.

## Interface
- `DATA_W`, 33 — signed pixel width, input and output.
- `IMG_W`, 24 — input image width in pixels. Must be even and ≥ 2.
- `IMG_H`, 24 — input image height in pixels. Must be even and ≥ 2.

- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `mode` in 1 — pooling mode: 0 = average, 1 = max. Sampled at the first pixel of each frame.
- `in_valid` in 1 — input pixel strobe.
- `in_data` in DATA_W — signed input pixel, raster order.
- `out_valid` out 1 — one-cycle strobe for each pooled pixel.
- `out_data` out DATA_W — signed pooled pixel.
- `out_row_last` out 1 — high with the last pooled pixel of an output row.
- `frame_done` out 1 — high with the last pooled pixel of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on `in_valid`.
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 at IMG_H-1 and the frame ends.
- Mode latch: `mode_q` loads `mode` when `in_valid` arrives at row 0, col 0. It is held for the whole frame. Changing `mode` mid-frame has no effect until the next frame.
- Horizontal stage, active on every pixel with odd `col`. It combines the pixel with the held even-col pixel into `h`:
  - avg: `h` = signed sum, DATA_W+1 bits.
  - max: `h` = signed max, sign-extended to DATA_W+1 bits.
- Even `row`: `h` is written to the line buffer at address `col>>1`.
- Odd `row`: the buffer entry at `col>>1` is read and combined with `h` into the window result:
  - avg: 4-pixel sum, DATA_W+2 bits, arithmetic shift right by 2 (floor toward −∞), truncated to DATA_W bits. No overflow is possible.
  - max: signed max, truncated to DATA_W bits.
- Outputs per frame: (IMG_W/2)·(IMG_H/2) pixels.
  - `out_row_last` is asserted when the window's `col` = IMG_W-1.
  - `frame_done` is asserted additionally when `row` = IMG_H-1.
- Gaps in `in_valid` are allowed anywhere. All state holds across gaps.
- Back-to-back frames need no idle cycle. Row 0 of the next frame may follow `frame_done` immediately.

## Timing
- Reset: `col`, `row`, `mode_q`, and the held even pixel go to 0. `out_valid`, `out_data`, `out_row_last`, and `frame_done` go to 0. Line buffer contents are don't-care.
- Reset mid-frame abandons the partial frame. The next `in_valid` after reset deasserts is treated as row 0, col 0.
- Latency: `out_valid` rises exactly 1 cycle after the `in_valid` cycle carrying the odd-row, odd-col pixel. Outputs are registered.
- Line buffer read uses a 0-cycle combinational address, or a registered read issued on the even-col pixel of the odd row. Either is acceptable provided the 1-cycle latency holds with gap-free input.
- `out_data` holds its last value when `out_valid` = 0.
- `in_valid` together with `rst`: reset wins and the pixel is dropped.

## Structure
- Package `pool_pkg` holds:
  - the `MODE_AVG` = 0 and `MODE_MAX` = 1 constants;
  - a `pool_max` function (signed max);
  - width helpers: `COL_W` = $clog2(IMG_W), `ROW_W` = $clog2(IMG_H).
- Sub-module `pool_line_buf` is a simple single-port-write / single-port-read RAM.
  - Depth IMG_W/2, width DATA_W+1.
  - Must infer distributed or block RAM.
- Elaboration-time check: IMG_W and IMG_H must be even, otherwise `$error`.

## Test plan
- Avg, 4×4 frame, DATA_W=16, pixels 1..16 in raster order → out 3, 5, 11, 13. `out_row_last` on the 2nd and 4th outputs. `frame_done` on the 4th only.
- Max, same frame → out 6, 8, 14, 16.
- Avg with negatives, window {-1,-2,-3,-3} → sum -9 → out -3 (floor). Max of {-1,-2,-3,-3} → -1.
- Mode change mid-frame: `mode` toggles from 0 to 1 after 5 pixels → the whole frame stays avg. The next frame runs max.
- Random `in_valid` gaps (≈30% idle) on a 24×24 frame against a reference model → identical output sequence. Exactly 144 strobes and one `frame_done`.
- `rst` asserted after 10 pixels of frame 1, then a clean 4×4 frame → no stray output. Results match the first scenario.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants and helpers for the 2x2 stride-2 pooling stage.
package pool_pkg;

  localparam logic MODE_AVG = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Widest operand pool_max accepts; callers sign-extend into it and truncate back.
  localparam int MAX_W = 64;

  function automatic logic signed [MAX_W-1:0] pool_max(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Counter/address width for a range of n values, never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer: one write port, one asynchronous read port.
module pool_line_buf #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 34,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it can map onto RAM primitives; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pool2d_stream.sv
// Streaming 2x2 stride-2 average/max pooling over a raster-order pixel stream.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 33,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_row_last,
  output logic                     frame_done
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam int HW    = DATA_W + 1;
  localparam int SW    = DATA_W + 2;
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = cnt_w(DEPTH);

  generate
    if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 2 || (IMG_H % 2) != 0) begin : g_bad_size
      $error("pool2d_stream: IMG_W and IMG_H must be even and >= 2");
    end
    if (SW > MAX_W) begin : g_bad_width
      $error("pool2d_stream: DATA_W too wide for pool_max");
    end
  endgenerate

  logic [COL_W-1:0]        col_q, col_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic                    mode_q, mode_d;
  logic signed [DATA_W-1:0] even_q, even_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                    out_row_last_q, out_row_last_d;
  logic                    frame_done_q, frame_done_d;

  logic                    col_last, row_last, frame_start;
  logic signed [HW-1:0]    h_sum, h_max, h;
  logic signed [HW-1:0]    lb_rdata;
  logic signed [SW-1:0]    win_sum;
  logic signed [DATA_W-1:0] win_avg, win_max;
  logic                    lb_we;
  logic [AW-1:0]           lb_addr;

  assign lb_addr = AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH (DEPTH),
    .WIDTH (HW),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (h),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  // Horizontal pair (held even-col pixel + current pixel) and the vertical combine with the buffered row.
  always_comb begin
    h_sum   = HW'(even_q) + HW'(in_data);
    h_max   = HW'(pool_max(MAX_W'(even_q), MAX_W'(in_data)));
    h       = (mode_q == MODE_MAX) ? h_max : h_sum;
    win_sum = SW'(lb_rdata) + SW'(h);
    win_avg = DATA_W'(win_sum >>> 2);
    win_max = DATA_W'(pool_max(MAX_W'(lb_rdata), MAX_W'(h)));
  end

  always_comb begin
    col_last    = (col_q == COL_W'(IMG_W - 1));
    row_last    = (row_q == ROW_W'(IMG_H - 1));
    frame_start = (col_q == '0) && (row_q == '0);

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    col_d          = col_q;
    row_d          = row_q;
    mode_d         = mode_q;
    even_d         = even_q;
    out_valid_d    = 1'b0;
    out_data_d     = out_data_q;
    out_row_last_d = 1'b0;
    frame_done_d   = 1'b0;
    lb_we          = 1'b0;

    if (in_valid) begin
      if (frame_start) begin
        mode_d = mode;
      end

      if (!col_q[0]) begin
        even_d = in_data;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_valid_d    = 1'b1;
        out_data_d     = (mode_q == MODE_MAX) ? win_max : win_avg;
        out_row_last_d = col_last;
        frame_done_d   = col_last && row_last;
      end

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; next-state math stays in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      mode_q         <= MODE_AVG;
      even_q         <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_row_last_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      mode_q         <= mode_d;
      even_q         <= even_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_row_last_q <= out_row_last_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_row_last = out_row_last_q;
  assign frame_done   = frame_done_q;

endmodule
